// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  localparam int         WDOG_W      = 7;
  localparam logic [6:0] MDU_TIMEOUT = 7'd64;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stalls, multi-cycle MDU waits,
// branch flushes and load-use interlocks, plus stall/flush counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs1_index,
  input  logic [4:0]  D_rs2_index,
  input  logic        D_use_rs1,
  input  logic        D_use_rs2,
  input  logic [4:0]  E_rd_index,
  input  logic        E_use_rd,
  input  logic        E_is_load,
  input  logic        E_jb,
  input  logic        im_req,
  input  logic        im_ready,
  input  logic        dm_req,
  input  logic        dm_ready,
  input  logic        mdu_start,
  input  logic        mdu_done,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        memwb_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic        mdu_timeout_err,
  output state_t      state
);

  state_t              state_nxt, eff_state;
  logic                ret_mdu, ret_mdu_nxt;
  logic                flush_pend, flush_pend_nxt;
  logic [WDOG_W-1:0]   wdog, wdog_nxt;
  logic                err_nxt;
  logic                mem_busy, load_use;

  assign mem_busy = (im_req & ~im_ready) | (dm_req & ~dm_ready);
  assign load_use = E_is_load & E_use_rd & (E_rd_index != 5'd0) &
                    ((D_use_rs1 & (D_rs1_index == E_rd_index)) |
                     (D_use_rs2 & (D_rs2_index == E_rd_index)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      ret_mdu         <= 1'b0;
      flush_pend      <= 1'b0;
      wdog            <= '0;
      mdu_timeout_err <= 1'b0;
    end else begin
      state           <= state_nxt;
      ret_mdu         <= ret_mdu_nxt;
      flush_pend      <= flush_pend_nxt;
      wdog            <= wdog_nxt;
      mdu_timeout_err <= err_nxt;
    end
  end

  always_comb begin
    pc_hold        = 1'b0;
    ifid_hold      = 1'b0;
    idex_hold      = 1'b0;
    exmem_hold     = 1'b0;
    memwb_hold     = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    exmem_bubble   = 1'b0;
    state_nxt      = state;
    ret_mdu_nxt    = ret_mdu;
    flush_pend_nxt = flush_pend;
    wdog_nxt       = wdog;
    err_nxt        = mdu_timeout_err;
    // A released memory wait acts in the same cycle as the state it interrupted.
    eff_state      = state;
    if (state == MEM_WAIT)
      eff_state = ret_mdu ? MDU_WAIT : RUN;

    if (!rst) begin
      if (mem_busy) begin
        {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold} = 5'b11111;
        state_nxt      = MEM_WAIT;
        flush_pend_nxt = flush_pend | E_jb;
        if (state == MDU_WAIT)
          ret_mdu_nxt = 1'b1;
        else if (state == RUN)
          ret_mdu_nxt = 1'b0;
      end else begin
        ret_mdu_nxt = 1'b0;
        if (eff_state == MDU_WAIT) begin
          if (mdu_done) begin
            state_nxt = RUN;
          end else begin
            {pc_hold, ifid_hold, idex_hold, exmem_bubble} = 4'b1111;
            wdog_nxt  = wdog + 1'b1;
            state_nxt = MDU_WAIT;
            if (wdog_nxt == MDU_TIMEOUT) begin
              err_nxt   = 1'b1;
              state_nxt = RUN;
            end
          end
        end else if (mdu_start) begin
          {pc_hold, ifid_hold, idex_hold, exmem_bubble} = 4'b1111;
          wdog_nxt  = '0;
          state_nxt = MDU_WAIT;
        end else if (E_jb || flush_pend) begin
          ifid_flush     = 1'b1;
          idex_bubble    = 1'b1;
          flush_pend_nxt = 1'b0;
          state_nxt      = RUN;
        end else begin
          if (load_use) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end
          state_nxt = RUN;
        end
      end
    end
  end

  sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pc_hold),
    .count (stall_cycles)
  );

  sat_counter #(.W(32)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (ifid_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, flush, memory/MDU waits,
// watchdog timeout and reset during a pending flush.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk, rst;
  logic [4:0]  D_rs1_index, D_rs2_index, E_rd_index;
  logic        D_use_rs1, D_use_rs2, E_use_rd, E_is_load, E_jb;
  logic        im_req, im_ready, dm_req, dm_ready, mdu_start, mdu_done;
  logic        pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold;
  logic        ifid_flush, idex_bubble, exmem_bubble, mdu_timeout_err;
  logic [31:0] stall_cycles, flush_count;
  state_t      state;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;

  // {pc, ifid, idex, exmem, memwb holds, ifid_flush, idex_bubble, exmem_bubble}
  localparam logic [7:0] C_NONE    = 8'b0000_0000;
  localparam logic [7:0] C_LOADUSE = 8'b1100_0010;
  localparam logic [7:0] C_FLUSH   = 8'b0000_0110;
  localparam logic [7:0] C_MEM     = 8'b1111_1000;
  localparam logic [7:0] C_MDU     = 8'b1110_0001;

  wire [7:0] ctl = {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold,
                    ifid_flush, idex_bubble, exmem_bubble};

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .D_rs1_index(D_rs1_index), .D_rs2_index(D_rs2_index),
    .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
    .E_rd_index(E_rd_index), .E_use_rd(E_use_rd), .E_is_load(E_is_load),
    .E_jb(E_jb),
    .im_req(im_req), .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
    .exmem_hold(exmem_hold), .memwb_hold(memwb_hold),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .mdu_timeout_err(mdu_timeout_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    D_rs1_index = 5'd0; D_rs2_index = 5'd0; D_use_rs1 = 1'b0; D_use_rs2 = 1'b0;
    E_rd_index = 5'd0; E_use_rd = 1'b0; E_is_load = 1'b0; E_jb = 1'b0;
    im_req = 1'b0; im_ready = 1'b1; dm_req = 1'b0; dm_ready = 1'b1;
    mdu_start = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    E_is_load = 1'b1; E_use_rd = 1'b1; E_rd_index = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic counters(input string tag);
    check({tag, "_stall"}, stall_cycles, exp_stall);
    check({tag, "_flush"}, flush_count, exp_flush);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    E_jb = 1'b1; dm_req = 1'b1; dm_ready = 1'b0; mdu_start = 1'b1;
    #1;
    check("rst_ctl", {24'd0, ctl}, {24'd0, C_NONE});
    check("rst_state", 32'(state), 32'(RUN));
    check("rst_err", {31'd0, mdu_timeout_err}, 32'd0);
    counters("rst");
    idle();
    tick();
    rst = 1'b0;

    // load-use on rs1
    load_in_ex(5'd5); D_rs1_index = 5'd5; D_use_rs1 = 1'b1;
    #1 check("lu_rs1", {24'd0, ctl}, {24'd0, C_LOADUSE});
    tick(); exp_stall += 1;
    idle();
    #1 check("lu_after", {24'd0, ctl}, {24'd0, C_NONE});
    counters("lu_rs1");

    // load-use on rs2 only
    load_in_ex(5'd7); D_rs2_index = 5'd7; D_use_rs2 = 1'b1; D_rs1_index = 5'd7;
    #1 check("lu_rs2", {24'd0, ctl}, {24'd0, C_LOADUSE});
    tick(); exp_stall += 1;
    // x0 destination never interlocks
    idle(); load_in_ex(5'd0); D_rs1_index = 5'd0; D_use_rs1 = 1'b1;
    #1 check("lu_x0", {24'd0, ctl}, {24'd0, C_NONE});
    tick();
    // matching index but source not used
    idle(); load_in_ex(5'd9); D_rs1_index = 5'd9; D_use_rs1 = 1'b0;
    #1 check("lu_unused", {24'd0, ctl}, {24'd0, C_NONE});
    tick();
    // non-load producer
    idle(); E_use_rd = 1'b1; E_rd_index = 5'd9; D_rs1_index = 5'd9; D_use_rs1 = 1'b1;
    #1 check("lu_nonload", {24'd0, ctl}, {24'd0, C_NONE});
    tick();

    // branch flush
    idle(); E_jb = 1'b1;
    #1 check("flush", {24'd0, ctl}, {24'd0, C_FLUSH});
    tick(); exp_flush += 1;
    idle();
    counters("flush");

    // load-use with branch: flush wins
    load_in_ex(5'd3); D_rs1_index = 5'd3; D_use_rs1 = 1'b1; E_jb = 1'b1;
    #1 check("lu_jb", {24'd0, ctl}, {24'd0, C_FLUSH});
    tick(); exp_flush += 1;
    idle();
    counters("lu_jb");

    // data memory stall for 3 cycles, branch in 2nd, flush on release
    dm_req = 1'b1; dm_ready = 1'b0;
    #1 check("mem_c1", {24'd0, ctl}, {24'd0, C_MEM});
    tick();
    E_jb = 1'b1;
    #1 check("mem_c2", {24'd0, ctl}, {24'd0, C_MEM});
    tick();
    E_jb = 1'b0;
    #1 check("mem_c3", {24'd0, ctl}, {24'd0, C_MEM});
    tick(); exp_stall += 3;
    check("mem_state", 32'(state), 32'(MEM_WAIT));
    idle();
    #1 check("mem_release", {24'd0, ctl}, {24'd0, C_FLUSH});
    tick(); exp_flush += 1;
    #1 check("mem_after", {24'd0, ctl}, {24'd0, C_NONE});
    check("mem_state_run", 32'(state), 32'(RUN));
    counters("mem");

    // MDU: start, 9 wait cycles, done on the 10th
    mdu_start = 1'b1;
    #1 check("mdu_start", {24'd0, ctl}, {24'd0, C_MDU});
    tick();
    mdu_start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      #1 check("mdu_wait", {24'd0, ctl}, {24'd0, C_MDU});
      tick();
    end
    check("mdu_state", 32'(state), 32'(MDU_WAIT));
    mdu_done = 1'b1;
    #1 check("mdu_done", {24'd0, ctl}, {24'd0, C_NONE});
    tick(); exp_stall += 10;
    idle();
    check("mdu_state_run", 32'(state), 32'(RUN));
    counters("mdu");

    // memory stall in the middle of an MDU wait returns to MDU_WAIT
    mdu_start = 1'b1;
    #1 check("mm_start", {24'd0, ctl}, {24'd0, C_MDU});
    tick();
    mdu_start = 1'b0;
    #1 check("mm_wait", {24'd0, ctl}, {24'd0, C_MDU});
    tick();
    im_req = 1'b1; im_ready = 1'b0;
    #1 check("mm_mem", {24'd0, ctl}, {24'd0, C_MEM});
    tick();
    check("mm_state_mem", 32'(state), 32'(MEM_WAIT));
    im_req = 1'b0; im_ready = 1'b1;
    #1 check("mm_release", {24'd0, ctl}, {24'd0, C_MDU});
    tick();
    check("mm_state_mdu", 32'(state), 32'(MDU_WAIT));
    mdu_done = 1'b1;
    #1 check("mm_done", {24'd0, ctl}, {24'd0, C_NONE});
    tick(); exp_stall += 4;
    idle();
    check("mm_state_run", 32'(state), 32'(RUN));
    counters("mm");

    // watchdog: no done for 64 MDU_WAIT cycles
    mdu_start = 1'b1;
    #1 check("wd_start", {24'd0, ctl}, {24'd0, C_MDU});
    tick();
    mdu_start = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      #1 check("wd_wait", {24'd0, ctl}, {24'd0, C_MDU});
      tick();
      if (i == 63) begin
        check("wd_pre_err", {31'd0, mdu_timeout_err}, 32'd0);
        check("wd_pre_state", 32'(state), 32'(MDU_WAIT));
      end
    end
    exp_stall += 65;
    check("wd_err", {31'd0, mdu_timeout_err}, 32'd1);
    check("wd_state", 32'(state), 32'(RUN));
    #1 check("wd_ctl", {24'd0, ctl}, {24'd0, C_NONE});
    tick();
    check("wd_sticky", {31'd0, mdu_timeout_err}, 32'd1);
    counters("wd");

    // reset during MEM_WAIT with a pending flush
    dm_req = 1'b1; dm_ready = 1'b0; E_jb = 1'b1;
    tick();
    E_jb = 1'b0;
    check("rmw_state", 32'(state), 32'(MEM_WAIT));
    rst = 1'b1;
    #1 check("rmw_ctl", {24'd0, ctl}, {24'd0, C_NONE});
    check("rmw_state_run", 32'(state), 32'(RUN));
    check("rmw_err", {31'd0, mdu_timeout_err}, 32'd0);
    exp_stall = 0; exp_flush = 0;
    counters("rmw");
    tick();
    idle();
    rst = 1'b0;
    #1 check("rmw_no_flush", {24'd0, ctl}, {24'd0, C_NONE});
    tick();
    #1 check("rmw_no_flush2", {24'd0, ctl}, {24'd0, C_NONE});
    counters("rmw_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock, rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 D_rs1_index, D_rs2_index  in  5 each  source register indices in ID.
REQ-004 D_use_rs1, D_use_rs2  in  1 each  ID instruction reads rs1/rs2.
REQ-005 E_rd_index  in  5;  E_use_rd  in  1;  E_is_load  in  1  destination info of the instruction in EX.
REQ-006 E_jb  in  1  taken branch/jump resolved in EX.
REQ-007 im_req, im_ready, dm_req, dm_ready  in  1 each  instruction/data memory handshake.
REQ-008 mdu_start  in  1  multi-cycle mul/div issued from EX;  mdu_done  in  1  result valid.
REQ-009 pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold  out  1 each  freeze the named register.
REQ-010 ifid_flush  out  1  zero the IF/ID register.
REQ-011 idex_bubble  out  1  drives the ID/EX stall/flush input (inserts NOP).
REQ-012 exmem_bubble  out  1  insert NOP into EX/MEM.
REQ-013 stall_cycles, flush_count  out  32 each  saturating performance counters.
REQ-014 mdu_timeout_err  out  1  sticky watchdog error.

Function
REQ-015 All control outputs (REQ-009..012) SHALL be combinational from current state, flush_pend and inputs; state, flush_pend, watchdog and counters SHALL be registered.
REQ-016 States SHALL be RUN, MEM_WAIT, MDU_WAIT.
REQ-017 mem_busy SHALL equal (im_req & ~im_ready) | (dm_req & ~dm_ready).
REQ-018 Priority, high to low: mem_busy, MDU wait, E_jb/flush_pend, load-use.
REQ-019 mem_busy in any state: all five holds = 1, no flush/bubble outputs; next = MEM_WAIT, remembering MDU_WAIT as the return state if the wait began there.
REQ-020 E_jb while mem_busy SHALL set flush_pend; flush_pend SHALL apply on the first non-busy cycle and then clear.
REQ-021 MEM_WAIT with mem_busy = 0: controller SHALL behave as RUN in that same cycle (zero-cycle release) and return to RUN, or to MDU_WAIT if so remembered.
REQ-022 RUN, mdu_start = 1, mem_busy = 0: pc_hold, ifid_hold, idex_hold = 1, exmem_bubble = 1; next = MDU_WAIT; watchdog cleared.
REQ-023 MDU_WAIT: same outputs as REQ-022 until mdu_done = 1; on mdu_done all holds = 0 that cycle, next = RUN.
REQ-024 Watchdog SHALL count MDU_WAIT cycles; reaching 64 SHALL set mdu_timeout_err (sticky) and force RUN.
REQ-025 Flush (E_jb or flush_pend, no mem_busy, not MDU_WAIT): ifid_flush = 1, idex_bubble = 1, no holds; flush_count += 1.
REQ-026 Load-use: E_is_load & E_use_rd & E_rd_index != 0 & ((D_use_rs1 & D_rs1_index == E_rd_index) | (D_use_rs2 & D_rs2_index == E_rd_index)) SHALL give pc_hold = 1, ifid_hold = 1, idex_bubble = 1 for one cycle.
REQ-027 Load-use together with E_jb: the flush SHALL win and the hold SHALL be suppressed.
REQ-028 stall_cycles SHALL increment on every cycle with pc_hold = 1.
REQ-029 Both counters SHALL saturate at 0xFFFF_FFFF.

Reset
REQ-030 rst SHALL force state = RUN, flush_pend = 0, watchdog = 0, counters = 0, mdu_timeout_err = 0, asynchronously.
REQ-031 While rst = 1, all control outputs SHALL be 0.
REQ-032 rst mid-wait SHALL abandon the wait with no pending flush retained.

Structure
REQ-033 Package pipe_ctrl_pkg SHALL hold the state enum and MDU_TIMEOUT = 64.
REQ-034 One sub-module, sat_counter (32-bit, enable input, saturating), SHALL be instantiated twice.

Verification
REQ-035 E: rd = 5, load; D: rs1 = 5 -> one cycle with pc_hold = ifid_hold = idex_bubble = 1; stall_cycles = 1.
REQ-036 E_jb = 1 for one cycle -> ifid_flush = idex_bubble = 1 that cycle; flush_count = 1.
REQ-037 dm_req = 1, dm_ready = 0 for 3 cycles, E_jb = 1 in the 2nd -> all holds for 3 cycles, then flush in the 4th cycle; flush_count = 1, stall_cycles = 3.
REQ-038 mdu_start, then mdu_done after 10 cycles -> 10 cycles of holds + exmem_bubble, released in the done cycle.
REQ-039 mdu_start with no mdu_done -> mdu_timeout_err = 1 after 64 cycles, state = RUN.
REQ-040 rst asserted during MEM_WAIT with flush_pend set -> outputs 0 immediately; after release no flush occurs and counters = 0.
